// File: rtl/jtag_tap_controller_pkg.sv
// debug_cfg_types: shared types for the JTAG TAP front end of the debug transport.
//   - dtmcs_t / dmi_t : register layouts exchanged with the DTM core
//   - tap_state_t     : the 16 IEEE 1149.1 TAP states
//   - ir_t + IR_*     : instruction codes; IR_RESET is the value loaded by reset/TLR
//   - decode_ir()     : IR -> selected data register
//   - tap_next()      : the standard TMS transition table
// Configuration macro: JTAG_IDCODE_EN. When defined, the IDCODE register exists and
// reset/TLR load IR=5'h01. When undefined, IR 01 decodes as BYPASS and reset/TLR load 5'h1F.
package debug_cfg_types;

    localparam int DMI_WIDTH   = 41;
    localparam int DTMCS_WIDTH = 32;
    localparam int IR_WIDTH    = 5;

    typedef logic [IR_WIDTH-1:0] ir_t;

    localparam ir_t IR_IDCODE = 5'h01;
    localparam ir_t IR_DTMCS  = 5'h10;
    localparam ir_t IR_DMI    = 5'h11;
    localparam ir_t IR_BYPASS = 5'h1F;

`ifdef JTAG_IDCODE_EN
    localparam ir_t IR_RESET = IR_IDCODE;
`else
    localparam ir_t IR_RESET = IR_BYPASS;
`endif

    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

    typedef struct packed {
        logic [6:0]  address;
        logic [31:0] data;
        logic [1:0]  op;
    } dmi_t;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE,
        SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } tap_state_t;

    typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI} dr_sel_t;

    function automatic dr_sel_t decode_ir(input ir_t ir);
        dr_sel_t sel;
        case (ir)
`ifdef JTAG_IDCODE_EN
            IR_IDCODE: sel = SEL_IDCODE;
`endif
            IR_DTMCS:  sel = SEL_DTMCS;
            IR_DMI:    sel = SEL_DMI;
            default:   sel = SEL_BYPASS;
        endcase
        return sel;
    endfunction

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        n = tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       n = tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:         n = tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:         n = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         n = tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:         n = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        n = tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:         n = tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:         n = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         n = tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:         n = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        n = tms ? SELECT_DR : RUN_TEST_IDLE;
            default:          n = TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_input_sync.sv
// jtag_input_sync: brings tck/tms/tdi into the clk domain and detects tck edges.
//   clk, reset      : system clock, asynchronous active-high reset
//   tck, tms, tdi   : raw JTAG pins (async to clk)
//   tck_rise        : one-clk pulse, synchronised tck went 0->1
//   tck_fall        : one-clk pulse, synchronised tck went 1->0
//   tms_s, tdi_s    : synchronised tms/tdi, aligned with the edge pulses
module jtag_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_s,
    output logic tdi_s
);

    logic [SYNC_STAGES-1:0] tck_sync_q, tck_sync_d;
    logic [SYNC_STAGES-1:0] tms_sync_q, tms_sync_d;
    logic [SYNC_STAGES-1:0] tdi_sync_q, tdi_sync_d;
    logic                   tck_prev_q, tck_prev_d;

    always_comb begin
        tck_sync_d = {tck_sync_q[SYNC_STAGES-2:0], tck};
        tms_sync_d = {tms_sync_q[SYNC_STAGES-2:0], tms};
        tdi_sync_d = {tdi_sync_q[SYNC_STAGES-2:0], tdi};
        tck_prev_d = tck_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            tck_sync_q <= tck_sync_d;
            tms_sync_q <= tms_sync_d;
            tdi_sync_q <= tdi_sync_d;
            tck_prev_q <= tck_prev_d;
        end
    end

    // All three pins go through the same depth, so tms/tdi seen with an edge pulse
    // are the values that were on the pins at that tck edge.
    assign tck_rise = tck_sync_q[SYNC_STAGES-1] & ~tck_prev_q;
    assign tck_fall = ~tck_sync_q[SYNC_STAGES-1] & tck_prev_q;
    assign tms_s    = tms_sync_q[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_tap_controller.sv
// jtag_tap_controller: oversampled IEEE 1149.1 TAP with a 5-bit IR and the IDCODE,
// DTMCS, DMI and BYPASS data registers, feeding the DTM core.
//   clk, reset            : system clock, asynchronous active-high reset
//   tck, tms, tdi, tdo    : JTAG pins (tdo registered, changes on tck fall only)
//   current_dtmcs/dmi     : values captured in Capture-DR for IR=DTMCS / IR=DMI
//   updated_dtmcs/dmi     : shifted-in value latched on entry to Update-DR
//   update_dtmcs/dmi      : one-clk strobes marking a new updated_* value
//   tap_state             : current TAP state, for observation/debug
// Configuration macro: JTAG_IDCODE_EN (IDCODE register present, reset IR=5'h01);
// when undefined IR 01 selects BYPASS and reset IR=5'h1F.
module jtag_tap_controller
    import debug_cfg_types::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    input  dtmcs_t     current_dtmcs,
    output dtmcs_t     updated_dtmcs,
    output logic       update_dtmcs,
    input  dmi_t       current_dmi,
    output dmi_t       updated_dmi,
    output logic       update_dmi,
    output tap_state_t tap_state
);

    logic tck_rise, tck_fall, tms_s, tdi_s;

    jtag_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tms_s    (tms_s),
        .tdi_s    (tdi_s)
    );

    tap_state_t           state_q, state_d;
    ir_t                  ir_q, ir_d;
    ir_t                  ir_shift_q, ir_shift_d;
    logic [DMI_WIDTH-1:0] sr_q, sr_d;
    logic                 tdo_q, tdo_d;
    dtmcs_t               updated_dtmcs_q, updated_dtmcs_d;
    dmi_t                 updated_dmi_q, updated_dmi_d;
    logic                 update_dtmcs_q, update_dtmcs_d;
    logic                 update_dmi_q, update_dmi_d;
    dr_sel_t              dr_sel;

    assign dr_sel = decode_ir(ir_q);

    always_comb begin
        state_d         = state_q;
        ir_d            = ir_q;
        ir_shift_d      = ir_shift_q;
        sr_d            = sr_q;
        tdo_d           = tdo_q;
        updated_dtmcs_d = updated_dtmcs_q;
        updated_dmi_d   = updated_dmi_q;
        update_dtmcs_d  = 1'b0;
        update_dmi_d    = 1'b0;

        if (tck_rise) begin
            state_d = tap_next(state_q, tms_s);

            // Register actions belong to the state being left on this rising edge.
            case (state_q)
                CAPTURE_IR: ir_shift_d = 5'b00001;
                SHIFT_IR:   ir_shift_d = {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
                CAPTURE_DR: begin
                    case (dr_sel)
                        SEL_IDCODE: sr_d = {9'b0, IDCODE_VALUE};
                        SEL_DTMCS:  sr_d = {9'b0, current_dtmcs};
                        SEL_DMI:    sr_d = current_dmi;
                        default:    sr_d = '0;
                    endcase
                end
                SHIFT_DR: begin
                    // tdi enters at the top of the selected length; bits above stay 0.
                    case (dr_sel)
                        SEL_DMI:    sr_d = {tdi_s, sr_q[DMI_WIDTH-1:1]};
                        SEL_BYPASS: sr_d = {40'b0, tdi_s};
                        default:    sr_d = {9'b0, tdi_s, sr_q[DTMCS_WIDTH-1:1]};
                    endcase
                end
                default: ;
            endcase

            // Update actions fire on entry to the target state.
            case (state_d)
                TEST_LOGIC_RESET: ir_d = IR_RESET;
                UPDATE_IR:        ir_d = ir_shift_q;
                UPDATE_DR: begin
                    if (dr_sel == SEL_DTMCS) begin
                        updated_dtmcs_d = dtmcs_t'(sr_q[DTMCS_WIDTH-1:0]);
                        update_dtmcs_d  = 1'b1;
                    end else if (dr_sel == SEL_DMI) begin
                        updated_dmi_d = dmi_t'(sr_q);
                        update_dmi_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // tdo moves only on the falling edge so it is settled for the host's next rise.
        if (tck_fall) begin
            if (state_q == SHIFT_DR) begin
                tdo_d = sr_q[0];
            end else if (state_q == SHIFT_IR) begin
                tdo_d = ir_shift_q[0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= TEST_LOGIC_RESET;
            ir_q            <= IR_RESET;
            ir_shift_q      <= '0;
            sr_q            <= '0;
            tdo_q           <= 1'b0;
            updated_dtmcs_q <= '0;
            updated_dmi_q   <= '0;
            update_dtmcs_q  <= 1'b0;
            update_dmi_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            ir_q            <= ir_d;
            ir_shift_q      <= ir_shift_d;
            sr_q            <= sr_d;
            tdo_q           <= tdo_d;
            updated_dtmcs_q <= updated_dtmcs_d;
            updated_dmi_q   <= updated_dmi_d;
            update_dtmcs_q  <= update_dtmcs_d;
            update_dmi_q    <= update_dmi_d;
        end
    end

    assign tdo           = tdo_q;
    assign updated_dtmcs = updated_dtmcs_q;
    assign updated_dmi   = updated_dmi_q;
    assign update_dtmcs  = update_dtmcs_q;
    assign update_dmi    = update_dmi_q;
    assign tap_state     = state_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Bench for jtag_tap_controller: drives TCK as a slow JTAG host, treats each IR/DR scan
// as a transaction and checks tdo streams, updated_* values and strobe counts against
// expectations computed from the register rules (capture value, length, update).
module tb_jtag_tap_controller;
    import debug_cfg_types::*;

    localparam logic [31:0] IDC = 32'h1BEE_F5A3;

`ifdef JTAG_IDCODE_EN
    localparam logic [4:0] MODEL_RESET_IR = 5'h01;
`else
    localparam logic [4:0] MODEL_RESET_IR = 5'h1F;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tck = 1'b0;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       tdo;
    dtmcs_t     current_dtmcs = '0;
    dtmcs_t     updated_dtmcs;
    logic       update_dtmcs;
    dmi_t       current_dmi = '0;
    dmi_t       updated_dmi;
    logic       update_dmi;
    tap_state_t tap_state;

    int test_cnt = 0;
    int fail_cnt = 0;
    int dtmcs_pulses = 0, dmi_pulses = 0, long_pulses = 0, overlaps = 0;
    logic prev_dtmcs = 1'b0, prev_dmi = 1'b0;
    logic [4:0] model_ir;

    jtag_tap_controller #(.IDCODE_VALUE(IDC), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .tck           (tck),
        .tms           (tms),
        .tdi           (tdi),
        .tdo           (tdo),
        .current_dtmcs (current_dtmcs),
        .updated_dtmcs (updated_dtmcs),
        .update_dtmcs  (update_dtmcs),
        .current_dmi   (current_dmi),
        .updated_dmi   (updated_dmi),
        .update_dmi    (update_dmi),
        .tap_state     (tap_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // strobe monitor
    always @(negedge clk) begin
        if (update_dtmcs) dtmcs_pulses++;
        if (update_dmi) dmi_pulses++;
        if ((update_dtmcs && prev_dtmcs) || (update_dmi && prev_dmi)) long_pulses++;
        if (update_dtmcs && update_dmi) overlaps++;
        prev_dtmcs = update_dtmcs;
        prev_dmi   = update_dmi;
    end

    task automatic check(input string tag, input logic [40:0] obs, input logic [40:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: register length and capture value for an IR code
    function automatic int dr_len_of(input logic [4:0] ir);
        if (ir == 5'h10) return 32;
        if (ir == 5'h11) return 41;
`ifdef JTAG_IDCODE_EN
        if (ir == 5'h01) return 32;
`endif
        return 1;
    endfunction

    function automatic logic [40:0] cap_of(input logic [4:0] ir);
        if (ir == 5'h10) return {9'b0, current_dtmcs};
        if (ir == 5'h11) return current_dmi;
`ifdef JTAG_IDCODE_EN
        if (ir == 5'h01) return {9'b0, IDC};
`endif
        return '0;
    endfunction

    // driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tck_cycle(input logic m, input logic d, output logic so);
        tms = m;
        tdi = d;
        wait_clk(5);
        so  = tdo;
        tck = 1'b1;
        wait_clk(5);
        tck = 1'b0;
    endtask

    task automatic reset_tap();
        logic s;
        repeat (5) tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        model_ir = MODEL_RESET_IR;
    endtask

    task automatic do_ir(input logic [4:0] v);
        logic       s;
        logic [4:0] got;
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, v[i], s);
            got[i] = s;
        end
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        check("ir_capture", {36'b0, got}, 41'h1);
        model_ir = v;
    endtask

    task automatic scan_dr(input logic [40:0] din, input int n, input int pause_at,
                           output logic [40:0] dout);
        logic s;
        dout = '0;
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        for (int i = 0; i < n; i++) begin
            tck_cycle((i == n - 1) || (i == pause_at), din[i], s);
            dout[i] = s;
            if (i == pause_at && i != n - 1) begin
                tck_cycle(1'b0, 1'b0, s);
                repeat (10) tck_cycle(1'b0, 1'b0, s);
                tck_cycle(1'b1, 1'b0, s);
                tck_cycle(1'b0, 1'b0, s);
            end
        end
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
    endtask

    task automatic do_dr(input string tag, input logic [40:0] din, input int n, input int pause_at);
        int          len, b_dt, b_dm, e_dt, e_dm;
        logic [40:0] got, cap, mask, exp_tdo;
        len  = dr_len_of(model_ir);
        cap  = cap_of(model_ir);
        b_dt = dtmcs_pulses;
        b_dm = dmi_pulses;
        scan_dr(din, n, pause_at, got);
        mask = (n >= 41) ? {41{1'b1}} : ((41'd1 << n) - 41'd1);
        exp_tdo = (len == 1) ? ({din[39:0], 1'b0} & mask) : (cap & mask);
        check({tag, "_tdo"}, got & mask, exp_tdo);
        wait_clk(8);
        e_dt = 0;
        e_dm = 0;
        if (model_ir == 5'h10) begin
            e_dt = 1;
            check({tag, "_updated_dtmcs"}, {9'b0, updated_dtmcs}, {9'b0, din[31:0]});
        end else if (model_ir == 5'h11) begin
            e_dm = 1;
            check({tag, "_updated_dmi"}, updated_dmi, din);
        end
        check({tag, "_dtmcs_pulses"}, 41'(dtmcs_pulses - b_dt), 41'(e_dt));
        check({tag, "_dmi_pulses"}, 41'(dmi_pulses - b_dm), 41'(e_dm));
    endtask

    initial begin
        logic        s;
        logic [40:0] din;
        logic [4:0]  ir_pick;
        int          b, n, len, pa;

        model_ir = MODEL_RESET_IR;

        // reset state
        wait_clk(4);
        check("rst_state", {37'b0, tap_state}, {37'b0, TEST_LOGIC_RESET});
        check("rst_tdo", {40'b0, tdo}, 41'h0);
        check("rst_strobes", {39'b0, update_dtmcs, update_dmi}, 41'h0);
        check("rst_updated_dmi", updated_dmi, 41'h0);
        reset = 1'b0;
        wait_clk(4);

        // 1: default IR after TLR
        reset_tap();
        din = 41'({$urandom(), $urandom()}) & 41'hFFFF_FFFF;
        do_dr("t1_reset_ir", din, 32, -1);

        // 2: DTMCS
        current_dtmcs = dtmcs_t'(32'h0000_7071);
        do_ir(5'h10);
        do_dr("t2_dtmcs", 41'h0001_0000, 32, -1);

        // 3: DMI write
        current_dmi = dmi_t'(41'({$urandom(), $urandom()}));
        do_ir(5'h11);
        do_dr("t3_dmi", 41'h40_0000_0006, 41, -1);
        check("t3_addr", {34'b0, updated_dmi.address}, 41'h10);
        check("t3_data", {9'b0, updated_dmi.data}, 41'h1);
        check("t3_op", {39'b0, updated_dmi.op}, 41'h2);

        // 4: BYPASS
        do_ir(5'h1F);
        do_dr("t4_bypass", 41'hA5, 8, -1);

        // 5: reset in the middle of a DMI shift
        do_ir(5'h11);
        b = dmi_pulses;
        tck_cycle(1'b1, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        tck_cycle(1'b0, 1'b0, s);
        repeat (20) tck_cycle(1'b0, 1'($urandom_range(0, 1)), s);
        reset = 1'b1;
        wait_clk(3);
        check("t5_state", {37'b0, tap_state}, {37'b0, TEST_LOGIC_RESET});
        check("t5_tdo", {40'b0, tdo}, 41'h0);
        check("t5_updated_dmi", updated_dmi, 41'h0);
        reset = 1'b0;
        tms = 1'b1;
        wait_clk(10);
        check("t5_no_strobe", 41'(dmi_pulses - b), 41'h0);
        reset_tap();

        // 6: pause mid-shift then resume
        current_dmi = dmi_t'(41'({$urandom(), $urandom()}));
        do_ir(5'h11);
        din = 41'({$urandom(), $urandom()});
        do_dr("t6_pause", din, 41, 17);

        // randomized scans
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 4))
                0: ir_pick = 5'h10;
                1: ir_pick = 5'h11;
                2: ir_pick = 5'h1F;
                3: ir_pick = 5'h01;
                default: ir_pick = 5'($urandom());
            endcase
            current_dtmcs = dtmcs_t'($urandom());
            current_dmi   = dmi_t'(41'({$urandom(), $urandom()}));
            do_ir(ir_pick);
            len = dr_len_of(ir_pick);
            n   = (len == 1) ? int'($urandom_range(2, 16)) : len;
            din = 41'({$urandom(), $urandom()});
            if (n < 41) din = din & ((41'd1 << n) - 41'd1);
            pa  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 2)) : -1;
            do_dr("rand_scan", din, n, pa);
        end

        check("strobe_width", 41'(long_pulses), 41'h0);
        check("strobe_overlap", 41'(overlaps), 41'h0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
